// File: rtl/imm_encode_loader.sv
//------------------------------------------------------------------------------
// Module     : imm_encode_loader
// Description: Packs RV32I operand fields and a decoder-format immediate into an
//              instruction word, checks immediate range and alignment, and streams
//              legal words to an instruction-memory write port at a wrapping
//              auto-incrementing address. Two-stage valid/ready pipeline.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_ctrl,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam logic [2:0] C_CTRL_R = 3'b000;
    localparam logic [2:0] C_CTRL_I = 3'b001;
    localparam logic [2:0] C_CTRL_S = 3'b010;
    localparam logic [2:0] C_CTRL_B = 3'b011;
    localparam logic [2:0] C_CTRL_U = 3'b100;
    localparam logic [2:0] C_CTRL_J = 3'b101;
    localparam logic [7:0] C_ERR_MAX = 8'hFF;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_fits12;
    logic              w_fits13;
    logic              w_fits21;
    logic              w_s2_free;
    logic              w_s1_moves;
    logic              w_in_fire;
    logic              w_s1_to_s2;
    logic              w_wr_fire;

    logic              r_s1_valid;
    logic              r_s1_legal;
    logic [31:0]       r_s1_word;
    logic              r_wr_valid;
    logic [31:0]       r_wr_data;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_err_count;

    // An immediate fits an N-bit signed field when all bits from N-1 upward agree.
    assign w_fits12 = (&imm_in[31:11]) | ~(|imm_in[31:11]);
    assign w_fits13 = (&imm_in[31:12]) | ~(|imm_in[31:12]);
    assign w_fits21 = (&imm_in[31:20]) | ~(|imm_in[31:20]);

    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (imm_ctrl)
            C_CTRL_R: begin
                w_word  = {funct7, rs2, rs1, funct3, rd, opcode};
                w_legal = 1'b1;
            end
            C_CTRL_I: begin
                w_word  = {imm_in[11:0], rs1, funct3, rd, opcode};
                w_legal = w_fits12;
            end
            C_CTRL_S: begin
                w_word  = {imm_in[11:5], rs2, rs1, funct3, imm_in[4:0], opcode};
                w_legal = w_fits12;
            end
            C_CTRL_B: begin
                w_word  = {imm_in[12], imm_in[10:5], rs2, rs1, funct3,
                           imm_in[4:1], imm_in[11], opcode};
                w_legal = w_fits13 & ~imm_in[0];
            end
            C_CTRL_U: begin
                w_word  = {imm_in[31:12], rd, opcode};
                w_legal = ~(|imm_in[11:0]);
            end
            C_CTRL_J: begin
                w_word  = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd, opcode};
                w_legal = w_fits21 & ~imm_in[0];
            end
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Illegal entries always leave stage 1 immediately; legal ones wait for stage 2.
    assign w_s2_free  = ~r_wr_valid | wr_ready;
    assign w_s1_moves = ~r_s1_legal | w_s2_free;
    assign in_ready   = rst_n & ~clear & (~r_s1_valid | w_s1_moves);
    assign w_in_fire  = in_valid & in_ready;
    assign w_s1_to_s2 = r_s1_valid & r_s1_legal & w_s2_free;
    assign w_wr_fire  = r_wr_valid & wr_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1_word  <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_legal <= w_legal;
            r_s1_word  <= w_word;
        end else if (r_s1_valid && w_s1_moves) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_addr  <= '0;
        end else if (clear) begin
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_addr  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (w_s1_to_s2) begin
                r_wr_valid <= 1'b1;
                r_wr_data  <= r_s1_word;
            end else if (wr_ready) begin
                r_wr_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
        end else if (err_pulse && (r_err_count != C_ERR_MAX)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_pulse = r_s1_valid & ~r_s1_legal & ~clear;
    assign err_count = r_err_count;
    assign wr_valid  = r_wr_valid & ~clear;
    assign wr_data   = r_wr_data;
    assign wr_addr   = r_wr_addr;

endmodule

`default_nettype wire

// File: tb/tb_imm_encode_loader.sv
//------------------------------------------------------------------------------
// Module     : tb_imm_encode_loader
// Description: Self-checking bench for imm_encode_loader against a capacity-level
//              queue model with bit-table immediate placement and range checks.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imm_encode_loader;

    localparam int C_AW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      imm_ctrl = '0;
    logic [6:0]      opcode = '0;
    logic [4:0]      rd = '0;
    logic [2:0]      funct3 = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic [6:0]      funct7 = '0;
    logic [31:0]     imm_in = '0;
    logic            wr_valid;
    logic            wr_ready;
    logic [C_AW-1:0] wr_addr;
    logic [31:0]     wr_data;
    logic            err_pulse;
    logic [7:0]      err_count;

    logic            wr_ready_dir = 1'b1;
    logic            wr_ready_rnd = 1'b1;
    logic            rr_en = 1'b0;
    assign wr_ready = rr_en ? wr_ready_rnd : wr_ready_dir;

    imm_encode_loader #(.ADDR_W(C_AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_ctrl(imm_ctrl), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm_in(imm_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] put(input logic [31:0] w, input int dst, input int src,
                                        input int len, input logic [31:0] imm);
        for (int i = 0; i < len; i++) w[dst+i] = imm[src+i];
        return w;
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] c, input logic [6:0] opc,
            input logic [4:0] frd, input logic [2:0] f3, input logic [4:0] fr1,
            input logic [4:0] fr2, input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'(opc);
        if (c inside {3'd0, 3'd1, 3'd4, 3'd5}) w = w + (32'(frd) << 7);
        if (c inside {3'd0, 3'd1, 3'd2, 3'd3}) w = w + (32'(f3) << 12) + (32'(fr1) << 15);
        if (c inside {3'd0, 3'd2, 3'd3})       w = w + (32'(fr2) << 20);
        if (c == 3'd0)                         w = w + (32'(f7) << 25);
        case (c)
            3'd1: w = put(w, 20, 0, 12, imm);
            3'd2: begin w = put(w, 25, 5, 7, imm); w = put(w, 7, 0, 5, imm); end
            3'd3: begin
                w = put(w, 31, 12, 1, imm); w = put(w, 25, 5, 6, imm);
                w = put(w, 8, 1, 4, imm);   w = put(w, 7, 11, 1, imm);
            end
            3'd4: w = put(w, 12, 12, 20, imm);
            3'd5: begin
                w = put(w, 31, 20, 1, imm); w = put(w, 21, 1, 10, imm);
                w = put(w, 20, 11, 1, imm); w = put(w, 12, 12, 8, imm);
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input logic [2:0] c, input logic [31:0] imm);
        int signed s;
        s = $signed(imm);
        case (c)
            3'd0:       return 1'b1;
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3:       return (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
            3'd4:       return (imm % 4096) == 0;
            3'd5:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm % 2 == 0);
            default:    return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] d;
        int          a;
    } wr_t;

    logic [31:0] q_w[$];
    int          q_acc[$];
    wr_t         wlog[$];
    int          exp_addr = 0;
    int          exp_cnt  = 0;
    bit          pend     = 1'b0;
    int          pulses   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    always @(posedge clk) cyc++;

    // Compare process: checks every cycle, then advances the model across the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_v;
            exp_v = (q_w.size() > 0) && !clear && (q_acc[0] + 1 <= cyc);
            chk("wr_valid", 32'(wr_valid), 32'(exp_v));
            if (wr_valid && q_w.size() > 0) begin
                chk("wr_data", wr_data, q_w[0]);
                chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
            end
            chk("in_ready", 32'(in_ready), 32'(!clear && (q_w.size() < 2 || wr_ready)));
            chk("err_pulse", 32'(err_pulse), 32'(pend && !clear));
            chk("err_count", 32'(err_count), 32'(exp_cnt));
            if (err_pulse) pulses++;
            if (clear) begin
                q_w.delete(); q_acc.delete();
                exp_addr = 0; exp_cnt = 0; pend = 1'b0;
            end else begin
                if (pend && exp_cnt < 255) exp_cnt++;
                pend = 1'b0;
                if (wr_valid && wr_ready && q_w.size() > 0) begin
                    wlog.push_back('{d: q_w[0], a: exp_addr});
                    void'(q_w.pop_front());
                    void'(q_acc.pop_front());
                    exp_addr = (exp_addr + 1) % (1 << C_AW);
                end
                if (in_valid && in_ready) begin
                    if (model_legal(imm_ctrl, imm_in)) begin
                        q_w.push_back(model_word(imm_ctrl, opcode, rd, funct3, rs1, rs2,
                                                 funct7, imm_in));
                        q_acc.push_back(cyc + 1);
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        wr_ready_rnd = ($urandom_range(0, 3) != 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [2:0] c, input logic [6:0] opc, input logic [4:0] frd,
                          input logic [2:0] f3, input logic [4:0] fr1, input logic [4:0] fr2,
                          input logic [6:0] f7, input logic [31:0] imm);
        imm_ctrl = c; opcode = opc; rd = frd; funct3 = f3;
        rs1 = fr1; rs2 = fr2; funct7 = f7; imm_in = imm;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] c, input logic [6:0] opc, input logic [4:0] frd,
                        input logic [2:0] f3, input logic [4:0] fr1, input logic [4:0] fr2,
                        input logic [6:0] f7, input logic [31:0] imm);
        set_in(c, opc, frd, f3, fr1, fr2, f7, imm);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_w.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain", 32'(q_w.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {{20{r[11]}}, r[11:0]};
            1: return {{19{r[12]}}, r[12:0]};
            2: return {{11{r[20]}}, r[20:0]};
            3: return r & 32'hFFFF_F000;
            4: return r;
            default: return {28'd0, r[3:0]};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Hand-computed encodings pin the model.
        chk("model_addi", model_word(3'b001, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h07B), 32'h07B00013);
        chk("model_jal", model_word(3'b101, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFE8), 32'hFE9FF0EF);
        chk("model_b_odd", 32'(model_legal(3'b011, 32'd3)), 32'd0);

        // Directed encodings, back-to-back; fifth write wraps address 3 -> 0.
        @(posedge clk); #1;
        wlog.delete();
        send(3'b001, 7'b0010011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'h0000007B);
        send(3'b010, 7'b0100011, 5'd0, 3'b010, 5'd0, 5'd0, 7'd0, 32'h00000141);
        send(3'b011, 7'b1100011, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'h00000004);
        send(3'b100, 7'b0110111, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'h0A455000);
        send(3'b101, 7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'hFFFFFFE8);
        drain();
        chk("dir_count", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5) begin
            chk("addi_data", wlog[0].d, 32'h07B00013); chk("addi_addr", 32'(wlog[0].a), 32'd0);
            chk("sw_data",   wlog[1].d, 32'h140020A3); chk("sw_addr",   32'(wlog[1].a), 32'd1);
            chk("beq_data",  wlog[2].d, 32'h00000263); chk("beq_addr",  32'(wlog[2].a), 32'd2);
            chk("lui_data",  wlog[3].d, 32'h0A455037); chk("lui_addr",  32'(wlog[3].a), 32'd3);
            chk("jal_data",  wlog[4].d, 32'hFE9FF0EF); chk("wrap_addr", 32'(wlog[4].a), 32'd0);
        end

        // Illegal inputs: dropped, counted, address untouched.
        wlog.delete();
        pulses = 0;
        send(3'b001, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000800);
        send(3'b011, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000003);
        send(3'b100, 7'h37, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000001);
        send(3'b111, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000000);
        drain();
        chk("ill_writes", 32'(wlog.size()), 32'd0);
        chk("ill_pulses", 32'(pulses), 32'd4);
        chk("ill_count", 32'(err_count), 32'd4);
        chk("ill_addr", 32'(wr_addr), 32'd1);

        // Backpressure: both stages fill, input stalls, stream resumes intact.
        wlog.delete();
        wr_ready_dir = 1'b0;
        send(3'b000, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'd0);
        send(3'b001, 7'h13, 5'd4, 3'd0, 5'd4, 5'd0, 7'd0, 32'hFFFFF800);
        set_in(3'b101, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h000FFFFE);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        wr_ready_dir = 1'b1;
        wait_accept();
        drain();
        chk("bp_count", 32'(wlog.size()), 32'd3);

        // Randomized stream with random write backpressure.
        rr_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 3'($urandom),
                 5'($urandom), 5'($urandom), 7'($urandom), rand_imm());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rr_en = 1'b0;
        wr_ready_dir = 1'b1;
        drain();

        // clear with both stages full: nothing written, address and count reset.
        wr_ready_dir = 1'b0;
        send(3'b100, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        send(3'b100, 7'h37, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'h54321000);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_addr", 32'(wr_addr), 32'd0);
        chk("clr_valid", 32'(wr_valid), 32'd0);
        chk("clr_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        wr_ready_dir = 1'b1;
        wlog.delete();
        send(3'b001, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'h00000010);
        drain();
        chk("clr_wcount", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("clr_first_addr", 32'(wlog[0].a), 32'd0);

        // err_count saturation.
        for (int i = 0; i < 260; i++)
            send(3'b110, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        drain();
        chk("sat_count", 32'(err_count), 32'd255);

        // Asynchronous reset mid-transfer.
        wr_ready_dir = 1'b0;
        send(3'b000, 7'h33, 5'd7, 3'd1, 5'd8, 5'd9, 7'd0, 32'd0);
        send(3'b000, 7'h33, 5'd10, 3'd2, 5'd11, 5'd12, 7'd0, 32'd0);
        @(posedge clk); #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", 32'(wr_valid), 32'd0);
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_err_pulse", 32'(err_pulse), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q_w.delete(); q_acc.delete();
        exp_addr = 0; exp_cnt = 0; pend = 1'b0;
        wr_ready_dir = 1'b1;
        mon_en = 1'b1;
        wlog.delete();
        send(3'b010, 7'h23, 5'd0, 3'd2, 5'd3, 5'd4, 7'd0, 32'hFFFFF801);
        drain();
        chk("arst_wcount", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("arst_first_addr", 32'(wlog[0].a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
